uart_rx_buffer: RTL

// - Downstream of the UART receiver: captures each received byte and its 3-bit error tag

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_fifo_mem.sv | 25 ++
 rtl/uart_rx_buffer.sv | 64 ++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths, error-tag bit positions and the stored entry layout.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_ERR_W = 3;
  localparam int ERR_PARITY = 0;
  localparam int ERR_START = 1;
  localparam int ERR_STOP = 2;
  typedef struct packed {
    logic [UART_ERR_W-1:0] err;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: DEPTH x entry register array with write-through registered read.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int EW = UART_ERR_W + UART_DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata,
  output logic [EW-1:0] rnext
);
  logic [EW-1:0] mem [DEPTH];
  // forwarding lets a write into an empty FIFO appear at the head without a bubble
  assign rnext = (we && waddr == raddr) ? wdata : mem[raddr];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdata <= '0;
    else rdata <= rnext;
endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: synchronises receiver done pulses and queues bytes plus error tags
// in a show-ahead FIFO with status, sticky overrun and level/error interrupt.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int THRESHOLD = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic [UART_ERR_W-1:0] rx_err,
  input  logic                  rd_en,
  input  logic                  clr_overrun,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic [UART_ERR_W-1:0] rd_err,
  output logic                  empty,
  output logic                  full,
  output logic [AW:0]           count,
  output logic                  overrun,
  output logic                  irq
);
  logic s1, s2, s3, push, pop, wr;
  logic [AW:0] wp, rp, wp_next, rp_next, cnt_next;
  rx_entry_t head, head_next;
  assign push = s2 & ~s3;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
  assign pop = rd_en & ~empty;
  // a pop in the same cycle frees the slot a push into a full FIFO needs
  assign wr = push & (~full | pop);
  assign wp_next = wp + (AW+1)'(wr);
  assign rp_next = rp + (AW+1)'(pop);
  assign cnt_next = wp_next - rp_next;
  assign rd_data = head.data;
  assign rd_err = head.err;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {s1, s2, s3} <= '0;
      wp <= '0;
      rp <= '0;
      overrun <= 1'b0;
      irq <= 1'b0;
    end else begin
      {s1, s2, s3} <= {rx_done, s1, s2};
      wp <= wp_next;
      rp <= rp_next;
      overrun <= (push & full & ~pop) | (overrun & ~clr_overrun);
      irq <= (cnt_next >= (AW+1)'(THRESHOLD)) | ((cnt_next != '0) & |head_next.err);
    end
  uart_rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .reset(reset),
    .we(wr),
    .waddr(wp[AW-1:0]),
    .wdata({rx_err, rx_data}),
    .raddr(rp_next[AW-1:0]),
    .rdata(head),
    .rnext(head_next)
  );
endmodule
